// File: rtl/uart_pkg.sv
// Register map, CTRL/STATUS bit positions and TX sequencer state type
// shared by the FIFO-buffered APB UART.
package uart_pkg;
   localparam logic [2:0] REG_TX_DATA = 3'd0;
   localparam logic [2:0] REG_RX_DATA = 3'd1;
   localparam logic [2:0] REG_CLK_DIV = 3'd2;
   localparam logic [2:0] REG_CTRL    = 3'd3;
   localparam logic [2:0] REG_STATUS  = 3'd4;
   localparam logic [2:0] REG_IRQ_EN  = 3'd5;

   localparam int CTRL_TX_EN    = 0;
   localparam int CTRL_RX_EN    = 1;
   localparam int CTRL_TX_FLUSH = 2;
   localparam int CTRL_RX_FLUSH = 3;

   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_RX_ERR   = 4;
   localparam int ST_RX_OVF   = 5;
   localparam int ST_TX_OVF   = 6;
   localparam int ST_TX_BUSY  = 7;

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with fall-through head, flush, and extra-MSB pointers so that
// full and empty are distinguished without a separate counter.
module uart_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [7:0]               wdata_i,
   input  logic                     pop_i,
   output logic [7:0]               rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   logic [7:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;

   assign level_o = wr_ptr - rd_ptr;
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (level_o == FULL_LVL);
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receive bit engine; samples mid-bit after a falling start edge and
// flags a low stop bit on rx_err_o alongside the rx_valid_o pulse.
module uart_rx (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic [31:0] clk_div_i,
   input  logic        rx_i,
   output logic        rx_valid_o,
   output logic [7:0]  rx_data_o,
   output logic        rx_err_o
);
   logic [2:0]  sync;
   logic        active;
   logic [3:0]  bits;
   logic [31:0] cnt, target;

   assign target = (bits == 4'd0) ? {1'b0, clk_div_i[31:1]} : clk_div_i;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         sync       <= 3'b111;
         active     <= 1'b0;
         bits       <= '0;
         cnt        <= '0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         rx_err_o   <= 1'b0;
      end else begin
         sync       <= {sync[1:0], rx_i};
         rx_valid_o <= 1'b0;
         if (!active) begin
            // Edge rather than level, so a low stop bit cannot retrigger.
            if (sync[2] && !sync[1]) begin
               active <= 1'b1;
               cnt    <= '0;
               bits   <= '0;
            end
         end else if (cnt != target) begin
            cnt <= cnt + 32'd1;
         end else begin
            cnt <= '0;
            if (bits == 4'd0) begin
               if (sync[1]) active <= 1'b0;
               else         bits   <= 4'd1;
            end else if (bits == 4'd9) begin
               active     <= 1'b0;
               rx_valid_o <= 1'b1;
               rx_err_o   <= ~sync[1];
            end else begin
               rx_data_o <= {sync[1], rx_data_o[7:1]};
               bits      <= bits + 4'd1;
            end
         end
      end
   end
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmit bit engine; each bit lasts clk_div_i+1 clocks, tx_done_o
// pulses once after the stop bit.
module uart_tx (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic [31:0] clk_div_i,
   input  logic        tx_valid_i,
   input  logic [7:0]  tx_data_i,
   output logic        tx_o,
   output logic        tx_done_o
);
   logic        active;
   logic [8:0]  shift;
   logic [3:0]  bits;
   logic [31:0] cnt;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         active    <= 1'b0;
         shift     <= '0;
         bits      <= '0;
         cnt       <= '0;
         tx_o      <= 1'b1;
         tx_done_o <= 1'b0;
      end else begin
         tx_done_o <= 1'b0;
         if (!active) begin
            if (tx_valid_i) begin
               active <= 1'b1;
               shift  <= {1'b1, tx_data_i};
               bits   <= '0;
               cnt    <= '0;
               tx_o   <= 1'b0;
            end
         end else if (cnt != clk_div_i) begin
            cnt <= cnt + 32'd1;
         end else begin
            cnt <= '0;
            if (bits == 4'd9) begin
               active    <= 1'b0;
               tx_done_o <= 1'b1;
            end else begin
               // The stop bit is the 1 shifted in at the top.
               tx_o  <= shift[0];
               shift <= {1'b1, shift[8:1]};
               bits  <= bits + 4'd1;
            end
         end
      end
   end
endmodule

// File: rtl/uart_fifo_apb.sv
// APB UART with TX/RX byte FIFOs, sticky error flags and flush controls.
// Define UART_FIFO_IRQ_EN to build the IRQ_EN register and irq_o logic.
module uart_fifo_apb
   import uart_pkg::*;
#(
   parameter int          TX_DEPTH    = 8,
   parameter int          RX_DEPTH    = 8,
   parameter logic [31:0] CLK_DIV_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [4:0]  paddr_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   input  logic        rx_i,
   output logic        tx_o,
   output logic        irq_o
);
   localparam int TXW = $clog2(TX_DEPTH) + 1;
   localparam int RXW = $clog2(RX_DEPTH) + 1;

   logic access, wr, rd, w1c, rstn;
   logic [2:0] idx, irq_en;
   logic [1:0] ctrl;
   logic [31:0] clk_div, status;
   logic rx_err_flag, rx_ovf_flag, tx_ovf_flag;
   tx_state_t state;
   logic tx_valid, tx_done;
   logic [7:0] tx_hold, tx_head, rx_head, rx_data;
   logic tx_push, tx_pop, tx_flush, tx_empty, tx_full;
   logic rx_push, rx_pop, rx_flush, rx_empty, rx_full;
   logic rx_valid, rx_err;
   logic [TXW-1:0] tx_level;
   logic [RXW-1:0] rx_level;
   logic unused;

   assign rstn     = ~rst_i;
   assign access   = psel_i & penable_i;
   assign wr       = access & pwrite_i;
   assign rd       = access & ~pwrite_i;
   assign idx      = paddr_i[4:2];
   assign pready_o = access;
   assign w1c      = wr && idx == REG_STATUS;
   assign unused   = ^paddr_i[1:0];

   assign tx_push  = wr && idx == REG_TX_DATA;
   assign tx_flush = wr && idx == REG_CTRL && pwdata_i[CTRL_TX_FLUSH];
   assign tx_pop   = ctrl[CTRL_TX_EN] && !tx_empty && (state == TX_IDLE || tx_done);
   assign rx_push  = rx_valid && ctrl[CTRL_RX_EN];
   assign rx_flush = wr && idx == REG_CTRL && pwdata_i[CTRL_RX_FLUSH];
   assign rx_pop   = rd && idx == REG_RX_DATA;

   uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_i(rst_i), .flush_i(tx_flush), .push_i(tx_push),
      .wdata_i(pwdata_i[7:0]), .pop_i(tx_pop), .rdata_o(tx_head),
      .empty_o(tx_empty), .full_o(tx_full), .level_o(tx_level));

   uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_i(rst_i), .flush_i(rx_flush), .push_i(rx_push),
      .wdata_i(rx_data), .pop_i(rx_pop), .rdata_o(rx_head),
      .empty_o(rx_empty), .full_o(rx_full), .level_o(rx_level));

   uart_tx u_tx (
      .clk(clk), .rstn_i(rstn), .clk_div_i(clk_div), .tx_valid_i(tx_valid),
      .tx_data_i(tx_hold), .tx_o(tx_o), .tx_done_o(tx_done));

   uart_rx u_rx (
      .clk(clk), .rstn_i(rstn), .clk_div_i(clk_div), .rx_i(rx_i),
      .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_err_o(rx_err));

   // Chaining straight from tx_done keeps TX_BUSY high across back-to-back bytes.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state    <= TX_IDLE;
         tx_valid <= 1'b0;
         tx_hold  <= '0;
      end else begin
         tx_valid <= 1'b0;
         case (state)
            TX_IDLE: if (tx_pop) begin
               state    <= TX_SEND;
               tx_hold  <= tx_head;
               tx_valid <= 1'b1;
            end
            TX_SEND: if (tx_done) begin
               if (tx_pop) begin
                  tx_hold  <= tx_head;
                  tx_valid <= 1'b1;
               end else begin
                  state <= TX_IDLE;
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         ctrl        <= '0;
         clk_div     <= CLK_DIV_RST;
         rx_err_flag <= 1'b0;
         rx_ovf_flag <= 1'b0;
         tx_ovf_flag <= 1'b0;
      end else begin
         if (wr && idx == REG_CLK_DIV) clk_div <= pwdata_i;
         if (wr && idx == REG_CTRL)    ctrl    <= pwdata_i[1:0];
         rx_err_flag <= (rx_err_flag & ~(w1c & pwdata_i[ST_RX_ERR])) | (rx_push & rx_err);
         rx_ovf_flag <= (rx_ovf_flag & ~(w1c & pwdata_i[ST_RX_OVF]))
                        | (rx_push & rx_full & ~rx_pop & ~rx_flush);
         tx_ovf_flag <= (tx_ovf_flag & ~(w1c & pwdata_i[ST_TX_OVF])) | (tx_push & tx_full & ~tx_pop);
      end
   end

   always_comb begin
      status              = '0;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_TX_FULL]  = tx_full;
      status[ST_RX_EMPTY] = rx_empty;
      status[ST_RX_FULL]  = rx_full;
      status[ST_RX_ERR]   = rx_err_flag;
      status[ST_RX_OVF]   = rx_ovf_flag;
      status[ST_TX_OVF]   = tx_ovf_flag;
      status[ST_TX_BUSY]  = (state == TX_SEND);
      status[15:8]        = 8'(rx_level);
      status[23:16]       = 8'(tx_level);
   end

   always_comb begin
      prdata_o = '0;
      if (rd) begin
         case (idx)
            REG_RX_DATA: prdata_o = {24'b0, rx_empty ? 8'h00 : rx_head};
            REG_CLK_DIV: prdata_o = clk_div;
            REG_CTRL:    prdata_o = {30'b0, ctrl};
            REG_STATUS:  prdata_o = status;
            REG_IRQ_EN:  prdata_o = {29'b0, irq_en};
            default:     prdata_o = '0;
         endcase
      end
   end

`ifdef UART_FIFO_IRQ_EN
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         irq_en <= '0;
         irq_o  <= 1'b0;
      end else begin
         if (wr && idx == REG_IRQ_EN) irq_en <= pwdata_i[2:0];
         // Sources in IRQ_EN bit order: {ERR, TX_EMPTY, RX_NOT_EMPTY}.
         irq_o <= |(irq_en & {rx_err_flag | rx_ovf_flag | tx_ovf_flag, tx_empty, ~rx_empty});
      end
   end
`else
   assign irq_en = '0;
   assign irq_o  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_apb.sv
// Directed/randomised bench for uart_fifo_apb against a queue-based model
// of the FIFOs and sticky flags; serial lines are decoded/driven at 8N1.
module tb_uart_fifo_apb;
   localparam int BIT = 5;   // clocks per bit with CLK_DIV = 4

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
   logic [4:0]  paddr_i = '0;
   logic [31:0] pwdata_i = '0;
   logic [31:0] prdata_o;
   logic        pready_o;
   logic        rx_i = 1'b1;
   logic        tx_o;
   logic        irq_o;

   int compared = 0;
   int mismatched = 0;
   logic        mon_en = 1'b0;
   logic [7:0]  tx_cap[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic        m_rx_err = 1'b0, m_rx_ovf = 1'b0, m_tx_ovf = 1'b0;

   uart_fifo_apb dut (
      .clk(clk), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
      .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
      .prdata_o(prdata_o), .pready_o(pready_o), .rx_i(rx_i), .tx_o(tx_o),
      .irq_o(irq_o));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
      @(negedge clk);
      penable_i = 1'b1;
      @(negedge clk);
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      $display("apb wr addr=%h data=%h", a, d);
   endtask

   task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
      @(negedge clk);
      penable_i = 1'b1;
      #1;
      d = prdata_o;
      check("pready", 32'(pready_o), 32'd1);
      @(negedge clk);
      psel_i = 1'b0; penable_i = 1'b0;
      $display("apb rd addr=%h data=%h", a, d);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      @(negedge clk);
      rx_i = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         repeat (BIT) @(negedge clk);
      end
      rx_i = stop;
      repeat (BIT) @(negedge clk);
      rx_i = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      $display("rx frame %h stop=%0b", d, stop);
   endtask

   task automatic wait_tx(input int n);
      for (int k = 0; k < 3000 && tx_cap.size() < n; k++) @(negedge clk);
      check("tx_count", tx_cap.size(), n);
   endtask

   function automatic logic [31:0] exp_status(input logic busy);
      logic [31:0] s;
      s = '0;
      s[0] = (txq.size() == 0);
      s[1] = (txq.size() == 8);
      s[2] = (rxq.size() == 0);
      s[3] = (rxq.size() == 8);
      s[4] = m_rx_err;
      s[5] = m_rx_ovf;
      s[6] = m_tx_ovf;
      s[7] = busy;
      s[15:8]  = 8'(rxq.size());
      s[23:16] = 8'(txq.size());
      return s;
   endfunction

   // Serial decoder on tx_o: mid-bit sampling from the start edge.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && tx_o === 1'b0) begin
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = tx_o;
            end
            repeat (BIT) @(negedge clk);
            check("tx_stop", 32'(tx_o), 32'd1);
            tx_cap.push_back(b);
            $display("tx byte %h", b);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdata;
      logic [7:0]  d;
      logic [31:0] exp;

      repeat (3) @(negedge clk);
      check("rst_prdata", prdata_o, 32'd0);
      check("rst_pready", 32'(pready_o), 32'd0);
      check("rst_tx", 32'(tx_o), 32'd1);
      check("rst_irq", 32'(irq_o), 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      apb_read(5'h08, rdata); check("clk_div_rst", rdata, 32'hFFFF_FFFF);
      apb_read(5'h10, rdata); check("status_rst", rdata, 32'h0000_0005);
      apb_read(5'h18, rdata); check("reg6", rdata, 32'd0);

      // Streaming TX with TX_EN set
      apb_write(5'h08, 32'd4);
      apb_write(5'h0C, 32'd1);
      mon_en = 1'b1;
      exp_tx = '{8'h55, 8'hA3, 8'h0F};
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'($urandom));
      foreach (exp_tx[i]) apb_write(5'h00, 32'(exp_tx[i]));
      for (int k = 0; k < 300 && tx_cap.size() < 6; k++) begin
         apb_read(5'h10, rdata);
         check("tx_busy", 32'(rdata[7]), 32'd1);
      end
      wait_tx(7);
      foreach (exp_tx[i]) check($sformatf("tx_byte%0d", i), 32'(tx_cap[i]), 32'(exp_tx[i]));
      repeat (20) @(negedge clk);
      apb_read(5'h10, rdata); check("status_tx_done", rdata, exp_status(1'b0));

      // TX overflow with TX_EN clear
      apb_write(5'h0C, 32'd0);
      for (int i = 0; i < 9; i++) begin
         d = 8'($urandom);
         apb_write(5'h00, 32'(d));
         if (txq.size() < 8) txq.push_back(d);
         else m_tx_ovf = 1'b1;
      end
      apb_read(5'h10, rdata); check("status_tx_ovf", rdata, exp_status(1'b0));
      apb_write(5'h10, 32'h40); m_tx_ovf = 1'b0;
      apb_read(5'h10, rdata); check("status_tx_w1c", rdata, exp_status(1'b0));

      // Drain, then flush mid-byte: the byte in flight completes, rest dropped
      tx_cap.delete();
      apb_write(5'h0C, 32'd1);
      wait_tx(1);
      repeat (15) @(negedge clk);
      apb_write(5'h0C, 32'd5);
      repeat (150) @(negedge clk);
      check("tx_flush_count", tx_cap.size(), 2);
      check("tx_flush_b0", 32'(tx_cap[0]), 32'(txq[0]));
      check("tx_flush_b1", 32'(tx_cap[1]), 32'(txq[1]));
      txq.delete();
      apb_read(5'h0C, rdata); check("ctrl_flush_rd", rdata, 32'd1);
      apb_read(5'h10, rdata); check("status_tx_flush", rdata, exp_status(1'b0));

      // RX fill past full
      apb_write(5'h0C, 32'd2);
      for (int v = 1; v <= 9; v++) begin
         send_frame(8'(v), 1'b1);
         if (rxq.size() < 8) rxq.push_back(8'(v));
         else m_rx_ovf = 1'b1;
      end
      apb_read(5'h10, rdata); check("status_rx_full", rdata, exp_status(1'b0));
      for (int i = 0; i < 9; i++) begin
         exp = (rxq.size() > 0) ? 32'(rxq.pop_front()) : 32'd0;
         apb_read(5'h04, rdata); check($sformatf("rx_read%0d", i), rdata, exp);
      end
      apb_read(5'h10, rdata); check("status_rx_drained", rdata, exp_status(1'b0));
      apb_write(5'h10, 32'h20); m_rx_ovf = 1'b0;

      // Random RX bytes
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1);
         rxq.push_back(d);
      end
      for (int i = 0; i < 3; i++) begin
         exp = 32'(rxq.pop_front());
         apb_read(5'h04, rdata); check($sformatf("rx_rand%0d", i), rdata, exp);
      end

      // Errored frame, flush, then W1C
      send_frame(8'h3C, 1'b0);
      rxq.push_back(8'h3C); m_rx_err = 1'b1;
      apb_read(5'h10, rdata); check("status_rx_err", rdata, exp_status(1'b0));
      apb_write(5'h0C, 32'd10); rxq.delete();
      apb_read(5'h10, rdata); check("status_rx_flush", rdata, exp_status(1'b0));
      apb_read(5'h0C, rdata); check("ctrl_rx_rd", rdata, 32'd2);
      apb_write(5'h10, 32'h10); m_rx_err = 1'b0;
      apb_read(5'h10, rdata); check("status_rx_w1c", rdata, exp_status(1'b0));

      // Bytes received while RX_EN is clear are discarded
      apb_write(5'h0C, 32'd0);
      send_frame(8'($urandom), 1'b0);
      apb_read(5'h10, rdata); check("status_rx_disabled", rdata, exp_status(1'b0));

      // Interrupt
      apb_write(5'h0C, 32'd2);
`ifdef UART_FIFO_IRQ_EN
      apb_write(5'h14, 32'd1);
      check("irq_idle", 32'(irq_o), 32'd0);
      send_frame(8'h7E, 1'b1);
      check("irq_rise", 32'(irq_o), 32'd1);
      apb_read(5'h14, rdata); check("irq_en_rd", rdata, 32'd1);
      apb_read(5'h04, rdata); check("irq_rx_byte", rdata, 32'h7E);
      check("irq_hold", 32'(irq_o), 32'd1);
      @(negedge clk);
      check("irq_fall", 32'(irq_o), 32'd0);
`else
      send_frame(8'h7E, 1'b1);
      check("irq_off_rx", 32'(irq_o), 32'd0);
      apb_write(5'h14, 32'd7);
      apb_read(5'h14, rdata); check("irq_en_rd0", rdata, 32'd0);
      check("irq_off_en", 32'(irq_o), 32'd0);
      apb_read(5'h04, rdata); check("irq_rx_byte", rdata, 32'h7E);
      check("irq_off_pop", 32'(irq_o), 32'd0);
`endif

      // Reset in the middle of a transmitted byte
      apb_write(5'h0C, 32'd1);
      apb_write(5'h00, 32'hC3);
      repeat (20) @(negedge clk);
      mon_en = 1'b0;
      rst_i = 1'b1;
      #1;
      check("rst_mid_tx", 32'(tx_o), 32'd1);
      @(negedge clk);
      rst_i = 1'b0;
      apb_read(5'h10, rdata); check("rst_mid_status", rdata, 32'h0000_0005);
      apb_read(5'h08, rdata); check("rst_mid_clkdiv", rdata, 32'hFFFF_FFFF);
      apb_read(5'h0C, rdata); check("rst_mid_ctrl", rdata, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
